// File: rtl/br.sv
// Register bank: 32 x 32-bit registers, two combinational read ports and one
// synchronous write port. x0 always reads as zero.
module br (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    input  logic [31:0] wd3,
    input  logic        we,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs_q [0:31];
    logic        wr_en;

    // x0 is never a legal write target, so the decode excludes it up front.
    assign wr_en = we && (a3 != 5'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: every entry is cleared explicitly; a register bank that must
            // read zero after reset cannot rely on power-up contents.
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'h0000_0000;
            end
        end else if (wr_en) begin
            regs_q[a3] <= wd3;
        end
    end

    // Reads are purely combinational with no write bypass; the address-zero
    // test keeps x0 at zero even if its storage were ever disturbed.
    assign rd1 = (a1 == 5'd0) ? 32'h0000_0000 : regs_q[a1];
    assign rd2 = (a2 == 5'd0) ? 32'h0000_0000 : regs_q[a2];

endmodule

// File: tb/tb_br.sv
// Self-checking bench for br: directed scenarios followed by random traffic,
// compared against an array-based reference model of the register file.
module tb_br;

    logic        clk;
    logic        rst_n;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int checks;
    int errors;

    logic [31:0] model [32];

    br dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a1    (a1),
        .a2    (a2),
        .a3    (a3),
        .wd3   (wd3),
        .we    (we),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[a];
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (we && a3 != 5'd0) begin
            model[a3] = wd3;
        end
    endtask

    // One clock cycle: drive at the falling edge, check the old contents just
    // before the rising edge, then the updated contents just after it.
    task automatic step(input string tag, input logic r, input logic w, input logic [4:0] wa,
                        input logic [31:0] d, input logic [4:0] ra1, input logic [4:0] ra2);
        @(negedge clk);
        rst_n = r; we = w; a3 = wa; wd3 = d; a1 = ra1; a2 = ra2;
        #1;
        check({tag, ".pre.rd1"}, rd1, exp_rd(a1));
        check({tag, ".pre.rd2"}, rd2, exp_rd(a2));
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".post.rd1"}, rd1, exp_rd(a1));
        check({tag, ".post.rd2"}, rd2, exp_rd(a2));
    endtask

    task automatic read_at(input string tag, input logic [4:0] ra1, input logic [4:0] ra2,
                           input logic [31:0] e1, input logic [31:0] e2);
        a1 = ra1; a2 = ra2;
        #1;
        check({tag, ".rd1"}, rd1, e1);
        check({tag, ".rd2"}, rd2, e2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; we = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd3 = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Initial reset: contents undefined until the first edge, so no pre-check.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) begin
            read_at("reset_sweep", 5'(i), 5'(31 - i), 32'h0, 32'h0);
        end

        step("write_x1", 1'b1, 1'b1, 5'd1, 32'h0000_000A, 5'd1, 5'd2);
        step("hold_x1", 1'b1, 1'b0, 5'd1, 32'h1111_1111, 5'd1, 5'd2);
        read_at("x1_value", 5'd1, 5'd2, 32'h0000_000A, 32'h0);

        step("write_x0", 1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        read_at("x0_protect", 5'd0, 5'd0, 32'h0, 32'h0);

        step("we_gate", 1'b1, 1'b0, 5'd5, 32'h1234_5678, 5'd5, 5'd5);
        read_at("x5_unwritten", 5'd5, 5'd0, 32'h0, 32'h0);

        step("write_x31", 1'b1, 1'b1, 5'd31, 32'hDEAD_BEEF, 5'd31, 5'd2);
        step("write_x2", 1'b1, 1'b1, 5'd2, 32'h0000_0002, 5'd31, 5'd2);
        read_at("dual_port", 5'd31, 5'd2, 32'hDEAD_BEEF, 32'h0000_0002);
        read_at("same_reg", 5'd31, 5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Back-to-back writes to one register: intermediate value lasts one cycle.
        step("b2b_first", 1'b1, 1'b1, 5'd7, 32'hAAAA_0001, 5'd7, 5'd7);
        read_at("b2b_mid", 5'd7, 5'd0, 32'hAAAA_0001, 32'h0);
        step("b2b_second", 1'b1, 1'b1, 5'd7, 32'hBBBB_0002, 5'd7, 5'd7);
        read_at("b2b_last", 5'd7, 5'd0, 32'hBBBB_0002, 32'h0);

        step("rst_pri", 1'b0, 1'b1, 5'd3, 32'h0000_0055, 5'd1, 5'd3);
        read_at("rst_pri_x", 5'd1, 5'd3, 32'h0, 32'h0);
        read_at("rst_pri_y", 5'd31, 5'd7, 32'h0, 32'h0);

        // Random traffic; read addresses often collide with the write address.
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        w;
            logic [4:0]  wa;
            logic [4:0]  ra1;
            logic [4:0]  ra2;
            logic [31:0] d;
            r   = ($urandom_range(99) >= 3);
            w   = ($urandom_range(99) < 60);
            wa  = 5'($urandom_range(31));
            d   = $urandom;
            ra1 = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
            ra2 = ($urandom_range(3) == 0) ? ra1 : 5'($urandom_range(31));
            step("rand", r, w, wa, d, ra1, ra2);
        end

        // Final full sweep of the model against the bank.
        @(negedge clk);
        rst_n = 1'b1; we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_at("final_sweep", 5'(i), 5'(31 - i), exp_rd(5'(i)), exp_rd(5'(31 - i)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
